// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the SRAM frame-buffer blocks. The pixel writer and
// the VGA pixel stream reader both use it.
//   AXI_RESP_OKAY : the only AXI write response that counts as success
//   wr_state_t    : states of the pixel writer's AXI write engine
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        ADDR_DATA,
        WAIT_B
    } wr_state_t;

endpackage

// File: rtl/fb_xy_to_addr.sv
// ---------------------------------------------------------------------------
// fb_xy_to_addr
// Combinational mapping of a screen coordinate to a linear frame-buffer
// address. Rows are stored back to back with a stride of H_VISIBLE words.
// Ports:
//   x    in  FB_X_BITS       column
//   y    in  FB_Y_BITS       row
//   addr out AXI_ADDR_WIDTH  y*H_VISIBLE + x, modulo 2**AXI_ADDR_WIDTH
// There is no range check here. Callers decide what to do with coordinates
// that fall off the screen.
// ---------------------------------------------------------------------------
module fb_xy_to_addr
    import fb_pkg::*;
#(
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int AXI_ADDR_WIDTH = 20,
    localparam int FB_X_BITS     = $clog2(H_VISIBLE),
    localparam int FB_Y_BITS     = $clog2(V_VISIBLE)
) (
    input  logic [FB_X_BITS-1:0]      x,
    input  logic [FB_Y_BITS-1:0]      y,
    output logic [AXI_ADDR_WIDTH-1:0] addr
);

    localparam logic [AXI_ADDR_WIDTH-1:0] ROW_STRIDE = AXI_ADDR_WIDTH'(H_VISIBLE);

    // Every operand is widened to the address width first, so the product
    // never overflows a narrower intermediate.
    assign addr = AXI_ADDR_WIDTH'(y) * ROW_STRIDE + AXI_ADDR_WIDTH'(x);

endmodule

// File: rtl/fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// fb_pixel_writer
// AXI write master that stores (x, y, color) pixels into the SRAM frame
// buffer. One register stage (p1) holds the pixel and its linear address.
// Each in-range pixel becomes one single-beat AXI write. Out-of-range pixels
// are dropped and reported on the sticky oob flag.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   fbw_valid/fbw_ready             pixel request handshake
//   fbw_x, fbw_y, fbw_color         pixel coordinate and color
//   busy                            p1 occupied or an AXI write in flight
//   oob                             sticky: out-of-range pixel dropped
//   wr_err                          sticky: non-OKAY write response seen
//   sram_axi_aw*/w*/b*              AXI write channels toward the SRAM
// Only one write is outstanding at a time, so writes complete in the same
// order the pixels arrived.
// ---------------------------------------------------------------------------
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int PIXEL_BITS     = 12,
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    localparam int FB_X_BITS     = $clog2(H_VISIBLE),
    localparam int FB_Y_BITS     = $clog2(V_VISIBLE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fbw_valid,
    output logic                        fbw_ready,
    input  logic [FB_X_BITS-1:0]        fbw_x,
    input  logic [FB_Y_BITS-1:0]        fbw_y,
    input  logic [PIXEL_BITS-1:0]       fbw_color,
    output logic                        busy,
    output logic                        oob,
    output logic                        wr_err,
    output logic [AXI_ADDR_WIDTH-1:0]   sram_axi_awaddr,
    output logic                        sram_axi_awvalid,
    input  logic                        sram_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   sram_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] sram_axi_wstrb,
    output logic                        sram_axi_wvalid,
    input  logic                        sram_axi_wready,
    input  logic [1:0]                  sram_axi_bresp,
    input  logic                        sram_axi_bvalid,
    output logic                        sram_axi_bready
);

    // Reject parameter sets that cannot work: a color wider than the data
    // bus, or a frame larger than the address space.
    if (PIXEL_BITS > AXI_DATA_WIDTH) begin : g_bad_pixel_bits
        $error("fb_pixel_writer: PIXEL_BITS must not exceed AXI_DATA_WIDTH");
    end
    if (longint'(H_VISIBLE) * longint'(V_VISIBLE) > (longint'(1) << AXI_ADDR_WIDTH)) begin : g_bad_addr_width
        $error("fb_pixel_writer: frame does not fit in AXI_ADDR_WIDTH address bits");
    end

    // The limits are one bit wider than the coordinates so that a limit
    // equal to a power of two is still representable.
    localparam logic [FB_X_BITS:0] X_LIMIT = (FB_X_BITS + 1)'(H_VISIBLE);
    localparam logic [FB_Y_BITS:0] Y_LIMIT = (FB_Y_BITS + 1)'(V_VISIBLE);

    wr_state_t                 state;
    wr_state_t                 next_state;
    logic                      p1_valid;
    logic                      p1_inrange;
    logic [AXI_ADDR_WIDTH-1:0] p1_addr;
    logic [PIXEL_BITS-1:0]     p1_color;
    logic [AXI_ADDR_WIDTH-1:0] in_addr;
    logic                      in_inrange;
    logic                      accept;
    logic                      launch;
    logic                      discard;
    logic                      b_hs;
    logic                      aw_done;
    logic                      w_done;

    fb_xy_to_addr #(
        .H_VISIBLE      (H_VISIBLE),
        .V_VISIBLE      (V_VISIBLE),
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH)
    ) u_xy_to_addr (
        .x    (fbw_x),
        .y    (fbw_y),
        .addr (in_addr)
    );

    assign in_inrange = ({1'b0, fbw_x} < X_LIMIT) && ({1'b0, fbw_y} < Y_LIMIT);

    // bready is tied high. Responses are always taken at once, including
    // stray ones that arrive while no write is outstanding.
    assign sram_axi_bready = 1'b1;
    assign sram_axi_wstrb  = '1;
    assign b_hs            = sram_axi_bvalid && sram_axi_bready;

    // A channel counts as done when its handshake has already happened
    // (valid dropped) or is happening in this cycle.
    assign aw_done = !sram_axi_awvalid || sram_axi_awready;
    assign w_done  = !sram_axi_wvalid  || sram_axi_wready;

    // p1 can leave in one of two ways. It launches when the write engine is
    // free, either idle or retiring its last write this cycle. It is
    // discarded when the pixel was off-screen. In both cases the slot is
    // free again in the same cycle, so the stream has no bubble.
    assign discard   = p1_valid && !p1_inrange;
    assign launch    = p1_valid && p1_inrange &&
                       ((state == IDLE) || ((state == WAIT_B) && b_hs));
    assign fbw_ready = !p1_valid || launch || discard;
    assign accept    = fbw_valid && fbw_ready;
    assign busy      = p1_valid || (state != IDLE);

    // Pipeline slot p1 holds one pixel. The address and range check are
    // computed on the way in. An accept in the same cycle the slot empties
    // refills it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_valid   <= 1'b0;
            p1_inrange <= 1'b0;
            p1_addr    <= '0;
            p1_color   <= '0;
        end else if (accept) begin
            p1_valid   <= 1'b1;
            p1_inrange <= in_inrange;
            p1_addr    <= in_addr;
            p1_color   <= fbw_color;
        end else if (launch || discard) begin
            p1_valid   <= 1'b0;
        end
    end

    // State register of the write engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. From ADDR_DATA the engine waits until both the
    // address and data handshakes are done, in either order. A response
    // that arrives outside WAIT_B has no effect on the state.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (launch) begin
                    next_state = ADDR_DATA;
                end
            end
            ADDR_DATA: begin
                if (aw_done && w_done) begin
                    next_state = WAIT_B;
                end
            end
            WAIT_B: begin
                if (b_hs) begin
                    next_state = launch ? ADDR_DATA : IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // AXI address and data channels. Both valids rise together on launch.
    // After that, each one drops on its own handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sram_axi_awvalid <= 1'b0;
            sram_axi_wvalid  <= 1'b0;
            sram_axi_awaddr  <= '0;
            sram_axi_wdata   <= '0;
        end else if (launch) begin
            sram_axi_awvalid <= 1'b1;
            sram_axi_wvalid  <= 1'b1;
            sram_axi_awaddr  <= p1_addr;
            sram_axi_wdata   <= AXI_DATA_WIDTH'(p1_color);
        end else begin
            if (sram_axi_awvalid && sram_axi_awready) begin
                sram_axi_awvalid <= 1'b0;
            end
            if (sram_axi_wvalid && sram_axi_wready) begin
                sram_axi_wvalid <= 1'b0;
            end
        end
    end

    // Sticky status flags. Only reset clears them. An error is recorded
    // only for the response to our own outstanding write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob    <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            if (discard) begin
                oob <= 1'b1;
            end
            if (b_hs && (state == WAIT_B) && (sram_axi_bresp != AXI_RESP_OKAY)) begin
                wr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// tb_fb_pixel_writer
// Self-checking bench for fb_pixel_writer. A reference model records every
// pixel the writer accepts. In-range pixels go into an ordered list of
// expected (address, data) writes, computed as y*640+x. Off-range pixels set
// the expected oob flag. An AXI slave model with configurable readiness
// answers each write, and every observed handshake is compared against the
// model.
// ---------------------------------------------------------------------------
module tb_fb_pixel_writer;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int PB = 12;
    localparam int XB = 10;
    localparam int YB = 9;

    logic          clk = 1'b0;
    logic          reset;
    logic          fbw_valid;
    logic          fbw_ready;
    logic [XB-1:0] fbw_x;
    logic [YB-1:0] fbw_y;
    logic [PB-1:0] fbw_color;
    logic          busy;
    logic          oob;
    logic          wr_err;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;

    fb_pixel_writer #(
        .PIXEL_BITS     (PB),
        .H_VISIBLE      (H),
        .V_VISIBLE      (V),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fbw_valid        (fbw_valid),
        .fbw_ready        (fbw_ready),
        .fbw_x            (fbw_x),
        .fbw_y            (fbw_y),
        .fbw_color        (fbw_color),
        .busy             (busy),
        .oob              (oob),
        .wr_err           (wr_err),
        .sram_axi_awaddr  (awaddr),
        .sram_axi_awvalid (awvalid),
        .sram_axi_awready (awready),
        .sram_axi_wdata   (wdata),
        .sram_axi_wstrb   (wstrb),
        .sram_axi_wvalid  (wvalid),
        .sram_axi_wready  (wready),
        .sram_axi_bresp   (bresp),
        .sram_axi_bvalid  (bvalid),
        .sram_axi_bready  (bready)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference model and scoreboard state.
    int unsigned exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int          aw_cyc[$];
    int          aw_cnt = 0;
    int          w_cnt  = 0;
    int          b_cnt  = 0;
    bit          exp_oob    = 1'b0;
    bit          exp_wr_err = 1'b0;

    // Slave behaviour controls.
    bit         aw_hold    = 1'b0;
    bit         w_hold     = 1'b0;
    bit         slave_rand = 1'b0;
    bit         resp_rand  = 1'b0;
    logic [1:0] bresp_force = 2'b00;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Cycle counter used to time-stamp address handshakes.
    always @(posedge clk) begin
        cyc++;
    end

    // Monitor and reference model. The inputs are stable at the falling
    // edge, so every valid/ready pair seen high here is a handshake that
    // happens at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (fbw_valid && fbw_ready) begin
                if (int'(fbw_x) < H && int'(fbw_y) < V) begin
                    exp_addr.push_back(int'(fbw_y) * H + int'(fbw_x));
                    exp_data.push_back(DW'(fbw_color));
                end else begin
                    exp_oob = 1'b1;
                end
            end
            if (awvalid && awready) begin
                if (aw_cnt < exp_addr.size())
                    checkOutput("awaddr", 32'(awaddr), exp_addr[aw_cnt]);
                else
                    checkOutput("aw_beyond_model", aw_cnt + 1, exp_addr.size());
                aw_cyc.push_back(cyc);
                aw_cnt++;
            end
            if (wvalid && wready) begin
                if (w_cnt < exp_data.size())
                    checkOutput("wdata", 32'(wdata), 32'(exp_data[w_cnt]));
                else
                    checkOutput("w_beyond_model", w_cnt + 1, exp_data.size());
                checkOutput("wstrb", 32'(wstrb), 32'h3);
                w_cnt++;
            end
            if (bvalid && bready) begin
                if (bresp != 2'b00) exp_wr_err = 1'b1;
                b_cnt++;
            end
        end
    end

    // AXI slave model. A response is offered once both the address and data
    // of a write have been taken and no response has yet been given for it.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            awready = 1'b0;
            wready  = 1'b0;
            bvalid  = 1'b0;
            bresp   = 2'b00;
        end else begin
            awready = aw_hold ? 1'b0 : (slave_rand ? 1'($urandom % 2) : 1'b1);
            wready  = w_hold  ? 1'b0 : (slave_rand ? 1'($urandom % 2) : 1'b1);
            bvalid  = 1'b0;
            if (imin(aw_cnt, w_cnt) > b_cnt && (!slave_rand || ($urandom % 3) != 0)) begin
                bvalid = 1'b1;
                bresp  = resp_rand ? ((($urandom % 4) == 0) ? 2'b10 : 2'b00) : bresp_force;
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one pixel and hold it until it is accepted. Returns just after
    // the accepting edge with fbw_valid still high, so the next call streams
    // back to back.
    task automatic applyStimulus(input int x, input int y, input int c);
        int waited;
        fbw_x     = XB'(x);
        fbw_y     = YB'(y);
        fbw_color = PB'(c);
        fbw_valid = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!fbw_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!fbw_ready) begin
            checkOutput("accept_timeout", 32'(fbw_ready), 32'd1);
            fbw_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dropValid();
        fbw_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((busy || bvalid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic clearModel();
        exp_addr.delete();
        exp_data.delete();
        aw_cyc.delete();
        aw_cnt     = 0;
        w_cnt      = 0;
        b_cnt      = 0;
        exp_oob    = 1'b0;
        exp_wr_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int x;
        int y;
        int addr_a;
        reset     = 1'b1;
        fbw_valid = 1'b0;
        fbw_x     = '0;
        fbw_y     = '0;
        fbw_color = '0;
        awready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        bresp     = 2'b00;

        // Values while reset is held.
        waitCycles(3);
        checkOutput("rst_awvalid", 32'(awvalid), 0);
        checkOutput("rst_wvalid",  32'(wvalid),  0);
        checkOutput("rst_bready",  32'(bready),  1);
        checkOutput("rst_busy",    32'(busy),    0);
        checkOutput("rst_oob",     32'(oob),     0);
        checkOutput("rst_wr_err",  32'(wr_err),  0);
        reset = 1'b0;
        waitCycles(2);

        // Single write to a zero-wait slave. awvalid must first be high two
        // cycles after the pixel is offered.
        applyStimulus(3, 2, 'hABC);
        dropValid();
        checkOutput("t1_awvalid_early", 32'(awvalid), 0);
        checkOutput("t1_busy", 32'(busy), 1);
        waitCycles(1);
        checkOutput("t1_awvalid", 32'(awvalid), 1);
        checkOutput("t1_wvalid",  32'(wvalid),  1);
        checkOutput("t1_awaddr",  32'(awaddr),  1283);
        checkOutput("t1_wdata",   32'(wdata),   32'h0ABC);
        checkOutput("t1_wstrb",   32'(wstrb),   3);
        waitIdle(20);
        checkOutput("t1_b_count", b_cnt, 1);

        // Back-to-back stream of eight pixels. One write every two cycles.
        base = aw_cyc.size();
        for (int i = 0; i < 8; i++) applyStimulus(i, 0, int'($urandom));
        dropValid();
        waitIdle(60);
        checkOutput("t2_count", aw_cyc.size() - base, 8);
        for (int i = 1; i < 8; i++)
            checkOutput("t2_spacing", aw_cyc[base + i] - aw_cyc[base + i - 1], 2);

        // Address backpressure. The data beat goes through immediately, while
        // the address waits with a stable value and the refilled slot blocks
        // new input.
        aw_hold = 1'b1;
        base    = aw_cnt;
        addr_a  = 5 * H + 10;
        applyStimulus(10, 5, 'h123);
        applyStimulus(11, 5, 'h456);
        dropValid();
        checkOutput("t3_awvalid_launch", 32'(awvalid), 1);
        waitCycles(1);
        checkOutput("t3_wvalid_dropped", 32'(wvalid), 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_awvalid_held", 32'(awvalid), 1);
            checkOutput("t3_awaddr_stable", 32'(awaddr), addr_a);
            checkOutput("t3_ready_low", 32'(fbw_ready), 0);
            waitCycles(1);
        end
        aw_hold = 1'b0;
        waitIdle(40);
        checkOutput("t3_count", aw_cnt - base, 2);

        // An out-of-range pixel is dropped, then the bottom-right corner is
        // written.
        checkOutput("t4_oob_before", 32'(oob), 0);
        applyStimulus(640, 0, 'h777);
        dropValid();
        checkOutput("t4_ready", 32'(fbw_ready), 1);
        waitCycles(1);
        checkOutput("t4_oob", 32'(oob), 1);
        checkOutput("t4_no_awvalid", 32'(awvalid), 0);
        checkOutput("t4_idle", 32'(busy), 0);
        applyStimulus(639, 479, 'h5A5);
        dropValid();
        waitCycles(1);
        checkOutput("t4_corner_awvalid", 32'(awvalid), 1);
        checkOutput("t4_corner_awaddr", 32'(awaddr), 307199);
        waitIdle(20);
        checkOutput("t4_oob_sticky", 32'(oob), 1);

        // An error response sets wr_err. Later writes still go out.
        checkOutput("t5_err_before", 32'(wr_err), 0);
        bresp_force = 2'b10;
        applyStimulus(1, 1, 'h111);
        dropValid();
        waitIdle(20);
        checkOutput("t5_wr_err", 32'(wr_err), 1);
        bresp_force = 2'b00;
        base = aw_cnt;
        applyStimulus(2, 1, 'h222);
        dropValid();
        waitIdle(20);
        checkOutput("t5_next_write", aw_cnt - base, 1);
        checkOutput("t5_err_sticky", 32'(wr_err), 1);

        // Reset while a write is waiting on the address channel.
        aw_hold = 1'b1;
        applyStimulus(20, 20, 'h321);
        dropValid();
        waitCycles(1);
        checkOutput("t6_awvalid_pending", 32'(awvalid), 1);
        #2;
        reset   = 1'b1;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        clearModel();
        #1;
        checkOutput("t6_awvalid_async", 32'(awvalid), 0);
        checkOutput("t6_wvalid_async",  32'(wvalid),  0);
        checkOutput("t6_bready",        32'(bready),  1);
        checkOutput("t6_oob_clear",     32'(oob),     0);
        checkOutput("t6_wr_err_clear",  32'(wr_err),  0);
        checkOutput("t6_busy_clear",    32'(busy),    0);
        aw_hold = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitCycles(1);
        applyStimulus(5, 6, 'h0F0);
        dropValid();
        waitCycles(1);
        checkOutput("t6_post_awaddr", 32'(awaddr), 6 * H + 5);
        waitIdle(20);
        checkOutput("t6_post_count", aw_cnt, 1);

        // Randomized traffic against a slave with random stalls and
        // occasional error responses.
        slave_rand = 1'b1;
        resp_rand  = 1'b1;
        for (int i = 0; i < 80; i++) begin
            x = (($urandom % 8) == 0) ? H + int'($urandom % 384) : int'($urandom % H);
            y = (($urandom % 8) == 0) ? V + int'($urandom % 32)  : int'($urandom % V);
            applyStimulus(x, y, int'($urandom));
            if (($urandom % 4) == 0) begin
                dropValid();
                waitCycles(int'($urandom % 3));
            end
        end
        dropValid();
        waitIdle(600);
        slave_rand = 1'b0;
        resp_rand  = 1'b0;
        waitCycles(2);

        checkOutput("final_aw_count", aw_cnt, exp_addr.size());
        checkOutput("final_w_count",  w_cnt,  exp_data.size());
        checkOutput("final_b_count",  b_cnt,  aw_cnt);
        checkOutput("final_oob",      32'(oob),    32'(exp_oob));
        checkOutput("final_wr_err",   32'(wr_err), 32'(exp_wr_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- AXI write master that stores (x, y, color) pixel writes into the SRAM frame buffer.
- It is the write-side counterpart of the VGA frame-buffer pixel stream reader.
- Upstream drawing logic hands it pixels over a valid/ready stream. The block computes the linear address `y*H_VISIBLE + x` in one pipeline stage and issues one single-beat AXI write per in-range pixel.
- Out-of-range pixels are dropped and flagged.

Parameters:
- PIXEL_BITS, 12, color width; must be <= AXI_DATA_WIDTH.
- H_VISIBLE, 640, visible columns; frame buffer row stride.
- V_VISIBLE, 480, visible rows.
- AXI_ADDR_WIDTH, 20, SRAM address width; elaboration error if H_VISIBLE*V_VISIBLE > 2**AXI_ADDR_WIDTH.
- AXI_DATA_WIDTH, 16, SRAM data width.
- FB_X_BITS (localparam), $clog2(H_VISIBLE), x width.
- FB_Y_BITS (localparam), $clog2(V_VISIBLE), y width.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- fbw_valid  in  1  pixel write request.
- fbw_ready  out  1  block accepts the request this cycle.
- fbw_x  in  FB_X_BITS  column.
- fbw_y  in  FB_Y_BITS  row.
- fbw_color  in  PIXEL_BITS  color.
- busy  out  1  pipeline or AXI transaction in flight.
- oob  out  1  sticky: an out-of-range pixel was dropped.
- wr_err  out  1  sticky: a bresp other than OKAY was received.
- sram_axi_awaddr  out  AXI_ADDR_WIDTH  write address.
- sram_axi_awvalid  out  1  write address valid.
- sram_axi_awready  in  1  write address ready.
- sram_axi_wdata  out  AXI_DATA_WIDTH  write data.
- sram_axi_wstrb  out  AXI_DATA_WIDTH/8  byte strobes, always all ones.
- sram_axi_wvalid  out  1  write data valid.
- sram_axi_wready  in  1  write data ready.
- sram_axi_bresp  in  2  write response.
- sram_axi_bvalid  in  1  response valid.
- sram_axi_bready  out  1  response ready.

Behaviour:
- Reset values:
  - awvalid = wvalid = 0.
  - bready = 1, held high for the entire time out of reset.
  - busy = oob = wr_err = 0.
  - State = IDLE, p1_valid = 0.
  - awaddr and wdata are don't-care until the first launch.
- Stage p1 (single slot):
  - On fbw_valid && fbw_ready, register x, y, color and p1_addr = y*H_VISIBLE + x, computed in AXI_ADDR_WIDTH bits.
  - Register p1_inrange = (x < H_VISIBLE) && (y < V_VISIBLE).
- fbw_ready = !p1_valid || launch || discard.
  - discard = p1_valid && !p1_inrange.
  - launch = p1_valid && p1_inrange && (state==IDLE || (state==WAIT_B && b_hs)).
- discard: drop p1 and set oob. No AXI activity results.
- FSM states: IDLE, ADDR_DATA, WAIT_B.
  - IDLE -> ADDR_DATA on launch. At that edge:
    - awaddr <= p1_addr.
    - wdata <= zero-extended color.
    - awvalid <= 1, wvalid <= 1.
  - ADDR_DATA: awvalid and wvalid each drop independently after their own handshake; either may complete first.
  - ADDR_DATA -> WAIT_B once both handshakes are done, including the cycle the second one completes.
  - WAIT_B -> ADDR_DATA on b_hs if launch; otherwise WAIT_B -> IDLE on b_hs.
  - bvalid seen outside WAIT_B (protocol violation) is accepted and ignored; the state does not change.
- Latency and throughput:
  - Pixel accepted at cycle N with slot empty and IDLE: awvalid/wvalid first high at N+2.
  - Zero-wait slave (ready=1, bvalid one cycle after the aw/w handshake): one write every 2 cycles.
  - Exactly one write outstanding at a time, so the issue order equals the input order.
- Responses:
  - On b_hs with bresp != 2'b00, set wr_err.
  - wr_err and oob clear only on reset.
- busy = p1_valid || state != IDLE.
- Simultaneous events:
  - A new accept in the same cycle as launch/discard refills p1. No bubble, no loss.
  - aw and w handshakes in the same cycle go straight to WAIT_B.
- Reset mid-transaction:
  - Asynchronous clear of everything; the outstanding write is abandoned.
  - The SRAM controller shares the reset.

Decomposition:
- Shared package fb_pkg:
  - AXI_RESP_OKAY = 2'b00.
  - Writer state enum {IDLE, ADDR_DATA, WAIT_B}.
- Sub-module fb_xy_to_addr (combinational y*H_VISIBLE + x, parameterised as above), reusable by the pixel stream reader.
- Everything else stays inline.

Test Plan:
- Single write, zero-wait slave:
  - Stimulus: x=3, y=2, color=12'hABC at cycle N.
  - Required: awaddr=1283, wdata=16'h0ABC, wstrb=2'b11, awvalid at N+2; busy falls after b_hs.
- Back-to-back stream, fbw_valid held high for 8 pixels (x=0..7, y=0):
  - Required: awaddr 0..7 in order, 2-cycle spacing, no duplicates or drops.
- Backpressure:
  - Stimulus: awready held low 5 cycles while wready=1.
  - Required: wvalid drops after 1 cycle, awvalid stays high with a stable awaddr, and fbw_ready=0 once p1 is full.
  - Then awready=1 -> WAIT_B, and the next write proceeds.
- Out of range, x=640, y=0:
  - Required: no awvalid, oob=1 sticky, fbw_ready stays high.
  - A following x=639, y=479 writes awaddr=307199.
- Error response:
  - Stimulus: slave returns bresp=2'b10.
  - Required: wr_err=1, FSM returns to IDLE, subsequent writes still issue.
- Reset mid-transaction:
  - Stimulus: assert reset while awvalid=1.
  - Required: awvalid/wvalid go to 0 asynchronously, bready=1, flags 0; the first post-reset pixel writes normally.
